// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode constants and the issue-stage payload type.
package alu_pkg;

  localparam int unsigned XLEN_SUPPORTED = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_control;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } issue_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t;

  // alt selects SUB/SRA over ADD/SRL (funct7 bit 5)
  function automatic logic [3:0] f3_to_alu(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decode into ALU operands and op code.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output issue_t      dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic        legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    legal = 1'b0;
    dec   = '0;
    dec.rd          = instr[11:7];
    dec.ALU_control = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        if (legal) begin
          dec.A           = rs1_data;
          dec.B           = rs2_data;
          dec.ALU_control = f3_to_alu(funct3, funct7[5]);
        end
      end
      OPC_OPIMM: begin
        // Only shifts constrain funct7; elsewhere those bits are immediate.
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
        if (legal) begin
          dec.A           = rs1_data;
          dec.B           = imm_i;
          dec.ALU_control = f3_to_alu(funct3, (funct3 == 3'b101) && funct7[5]);
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        dec.B = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        dec.A = pc;
        dec.B = imm_u;
      end
      default: legal = 1'b0;
    endcase
    dec.illegal   = !legal;
    dec.reg_write = legal && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, then a 2-entry skid buffer so ALU inputs come from flops.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALU_control,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);

  issue_t      dec;
  issue_t      out_q;
  issue_t      skid_q;
  skid_state_t state_q, state_d;
  logic        accept, consume;
  logic        load_out, out_from_skid, load_skid;

  alu_op_decoder u_dec (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = SKID_EN ? (state_q != ST_TWO) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = out_valid && out_ready && !flush;

  // With SKID_EN=0 an accept in ONE always coincides with a consume, so TWO is unreachable.
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d  = ST_ONE;
          load_out = 1'b1;
        end
        ST_ONE: begin
          if (accept && consume) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (consume) begin
          state_d       = ST_ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_out)  out_q  <= out_from_skid ? skid_q : dec;
      if (load_skid) skid_q <= dec;
    end
  end

  assign A           = out_q.A;
  assign B           = out_q.B;
  assign ALU_control = out_q.ALU_control;
  assign rd          = out_q.rd;
  assign reg_write   = out_q.reg_write;
  assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model plus directed literal checks.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, A, B;
  logic [3:0]  ALU_control;
  logic [4:0]  rd;
  logic        reg_write, illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t q[$];

  alu_issue_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B),
    .ALU_control(ALU_control), .rd(rd), .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [3:0] op_of_f3 [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       ok;
    op_of_f3 = '{4'd0, 4'd5, 4'd9, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};
    opc = ins[6:0];
    f7  = ins[31:25];
    f3  = ins[14:12];
    e.a = 0; e.b = 0; e.ctl = 0; e.rd = ins[11:7];
    ok  = 1'b0;
    if (opc == 7'h33) begin
      ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      if (ok) begin
        e.a = r1; e.b = r2; e.ctl = op_of_f3[f3];
        if (f7 == 7'h20) e.ctl = (f3 == 0) ? 4'd1 : 4'd7;
      end
    end else if (opc == 7'h13) begin
      if (f3 == 1)      ok = (f7 == 0);
      else if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
      else              ok = 1'b1;
      if (ok) begin
        e.a = r1;
        e.b = {{20{ins[31]}}, ins[31:20]};
        e.ctl = (f3 == 5 && f7 == 7'h20) ? 4'd7 : op_of_f3[f3];
      end
    end else if (opc == 7'h37) begin
      ok = 1'b1; e.b = ins & 32'hFFFFF000;
    end else if (opc == 7'h17) begin
      ok = 1'b1; e.a = p; e.b = ins & 32'hFFFFF000;
    end
    e.ill = !ok;
    e.rw  = ok && (e.rd != 0);
    return e;
  endfunction

  // Compare DUT against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_ctl", ALU_control, 0);
      chk("rst_rd", rd, 0);
      chk("rst_rw", reg_write, 0);
      chk("rst_ill", illegal, 0);
      q.delete();
    end else begin
      bit acc, con;
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("m_A", A, q[0].a);
        chk("m_B", B, q[0].b);
        chk("m_ctl", ALU_control, q[0].ctl);
        chk("m_rd", rd, q[0].rd);
        chk("m_rw", reg_write, q[0].rw);
        chk("m_ill", illegal, q[0].ill);
      end
      acc = in_valid && (q.size() < 2) && !flush;
      con = (q.size() > 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(ref_decode(instr, pc, rs1_data, rs2_data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  f7;
    int unsigned k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3)      opc = 7'h33;
    else if (k <= 6) opc = 7'h13;
    else if (k == 7) opc = 7'h37;
    else if (k == 8) opc = 7'h17;
    else             opc = r[6:0];
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], opc};
  endfunction

  initial begin
    rst = 1'b1; flush = 0; in_valid = 0; out_ready = 0;
    instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("init_in_ready", in_ready, 1);

    // ADD x3,x1,x2
    out_ready = 1;
    offer(32'h002081B3, 0, 5, 7);
    step(); in_valid = 0;
    chk("add_A", A, 5); chk("add_B", B, 7); chk("add_ctl", ALU_control, 0);
    chk("add_rd", rd, 3); chk("add_rw", reg_write, 1); chk("add_valid", out_valid, 1);

    // SRAI x5,x6,4 then AUIPC x1,0x12345 back to back
    offer(32'h40435293, 0, 32'h80000000, 0);
    step();
    chk("srai_shamt", {27'b0, B[4:0]}, 4); chk("srai_ctl", ALU_control, 4'b0111);
    chk("srai_A", A, 32'h80000000); chk("srai_rd", rd, 5);
    offer(32'h12345097, 32'h100, 0, 0);
    step(); in_valid = 0;
    chk("auipc_A", A, 32'h100); chk("auipc_B", B, 32'h12345000);
    chk("auipc_ctl", ALU_control, 0); chk("auipc_rd", rd, 1);

    // Illegal load, illegal OP f7=0000001, ADDI x0
    offer(32'h00012083, 0, 3, 4);
    step();
    chk("load_ill", illegal, 1); chk("load_rw", reg_write, 0);
    chk("load_ctl", ALU_control, 0); chk("load_A", A, 0); chk("load_B", B, 0);
    offer(32'h022081B3, 0, 3, 4);
    step();
    chk("mul_ill", illegal, 1); chk("mul_rw", reg_write, 0); chk("mul_ctl", ALU_control, 0);
    offer(32'h00500013, 0, 9, 0);
    step(); in_valid = 0;
    chk("addi0_rw", reg_write, 0); chk("addi0_ill", illegal, 0); chk("addi0_B", B, 5);
    step();

    // Back-pressure with three back-to-back inputs
    out_ready = 0;
    offer(32'h00100093, 0, 0, 0);
    step(); chk("bp1_in_ready", in_ready, 1); chk("bp1_rd", rd, 1);
    offer(32'h00200113, 0, 0, 0);
    step(); chk("bp2_in_ready", in_ready, 0); chk("bp2_rd", rd, 1); chk("bp2_B", B, 1);
    offer(32'h00300193, 0, 0, 0);
    step(); chk("bp3_in_ready", in_ready, 0); chk("bp3_rd", rd, 1);
    out_ready = 1;
    step(); chk("bp4_rd", rd, 2); chk("bp4_B", B, 2); chk("bp4_in_ready", in_ready, 1);
    step(); in_valid = 0; chk("bp5_rd", rd, 3); chk("bp5_valid", out_valid, 1);
    step(); chk("bp6_valid", out_valid, 0);

    // Flush with two entries held, then with one entry and a takeable input
    out_ready = 0;
    offer(32'h00100093, 0, 0, 0); step();
    offer(32'h00200113, 0, 0, 0); step();
    chk("fl_full", in_ready, 0);
    offer(32'h00400213, 0, 0, 0); flush = 1;
    step(); flush = 0; in_valid = 0;
    chk("fl_valid", out_valid, 0); chk("fl_in_ready", in_ready, 1);
    step(); chk("fl_drop", out_valid, 0);
    offer(32'h00100093, 0, 0, 0); step();
    offer(32'h00400213, 0, 0, 0); flush = 1;
    step(); flush = 0; in_valid = 0;
    chk("fl1_valid", out_valid, 0);
    step(); chk("fl1_drop", out_valid, 0);

    // Reset with two entries held
    offer(32'h002081B3, 0, 5, 7); step();
    offer(32'h002081B3, 0, 6, 8); step();
    in_valid = 0;
    rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0); chk("mrst_A", A, 0); chk("mrst_B", B, 0);
    chk("mrst_rd", rd, 0); chk("mrst_rw", reg_write, 0);
    @(posedge clk); #1 rst = 1'b0;
    chk("mrst_in_ready", in_ready, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      instr     = rand_instr();
      pc        = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
